// File: rtl/bit_stream_feeder.sv
// Serializes bytes into a single-bit character stream for a chain of NFA match stages,
// generating the start token, stage clear, frame-relative bit index and end-of-stream pulse.
//
// state | meaning
// IDLE  | no byte loaded; ip_c/bit_valid low, ready for a new byte
// SHIFT | shreg bit on ip_c each cycle; reload allowed on bit 7 of a non-final byte
module bit_stream_feeder #(
   parameter int ANCHORED  = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        byte_last,
   output logic        byte_ready,
   output logic        ip_c,
   output logic        bit_valid,
   output logic        start,
   output logic        nfa_reset,
   output logic [15:0] bit_index,
   output logic        eos
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        last_flag_q, last_flag_d;
   logic        in_frame_q, in_frame_d;
   logic        first_flag_q, first_flag_d;
   logic [15:0] bit_index_q, bit_index_d;
   logic        eos_q, eos_d;

   logic busy;
   logic cnt_end;
   logic accept;

   assign busy    = (state_q == SHIFT);
   assign cnt_end = (bit_cnt_q == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= 8'h00;
         bit_cnt_q    <= 3'd0;
         last_flag_q  <= 1'b0;
         in_frame_q   <= 1'b0;
         first_flag_q <= 1'b0;
         bit_index_q  <= 16'h0000;
         eos_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         last_flag_q  <= last_flag_d;
         in_frame_q   <= in_frame_d;
         first_flag_q <= first_flag_d;
         bit_index_q  <= bit_index_d;
         eos_q        <= eos_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      last_flag_d  = last_flag_q;
      in_frame_d   = in_frame_q;
      first_flag_d = first_flag_q;
      bit_index_d  = bit_index_q;
      eos_d        = 1'b0;

      if (busy) begin
         // Frame end clears the index; the first bit restarts it regardless of history.
         if (cnt_end && last_flag_q)
            bit_index_d = 16'h0000;
         else if (first_flag_q)
            bit_index_d = 16'h0001;
         else if (bit_index_q != 16'hFFFF)
            bit_index_d = bit_index_q + 16'h0001;
      end

      if (accept) begin
         state_d      = SHIFT;
         shreg_d      = byte_in;
         bit_cnt_d    = 3'd0;
         last_flag_d  = byte_last;
         in_frame_d   = 1'b1;
         first_flag_d = !in_frame_q;
      end else if (busy) begin
         shreg_d      = (MSB_FIRST != 0) ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
         bit_cnt_d    = bit_cnt_q + 3'd1;
         first_flag_d = 1'b0;
         if (cnt_end) begin
            state_d = IDLE;
            if (last_flag_q) begin
               in_frame_d = 1'b0;
               eos_d      = 1'b1;
            end
         end
      end
   end

   always_comb begin
      byte_ready = !busy || (cnt_end && !last_flag_q);
      accept     = byte_valid && byte_ready && !reset;
      bit_valid  = busy;
      ip_c       = 1'b0;
      if (busy)
         ip_c = (MSB_FIRST != 0) ? shreg_q[7] : shreg_q[0];
      if (ANCHORED != 0)
         start = accept && !in_frame_q;
      else
         start = accept || (busy && !cnt_end && !reset);
      nfa_reset  = reset || (!in_frame_q && !accept);
      bit_index  = bit_index_q;
      eos        = eos_q;
   end

endmodule

// File: tb/tb_bit_stream_feeder.sv
// Scoreboard bench: two feeder instances (unanchored MSB-first, anchored LSB-first) share inputs;
// accepted bytes push expected bits into a queue that a negedge monitor pops and compares.
module tb_bit_stream_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_last;

   logic        ready_a, ip_a, valid_a, start_a, nfa_a, eos_a;
   logic [15:0] idx_a;
   logic        ready_b, ip_b, valid_b, start_b, nfa_b, eos_b;
   logic [15:0] idx_b;

   always #5 clk = ~clk;

   bit_stream_feeder #(.ANCHORED(0), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(ready_a), .ip_c(ip_a), .bit_valid(valid_a),
      .start(start_a), .nfa_reset(nfa_a), .bit_index(idx_a), .eos(eos_a)
   );

   bit_stream_feeder #(.ANCHORED(1), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(ready_b), .ip_c(ip_b), .bit_valid(valid_b),
      .start(start_b), .nfa_reset(nfa_b), .bit_index(idx_b), .eos(eos_b)
   );

   typedef struct packed {
      logic        msb_bit;
      logic        lsb_bit;
      logic [15:0] idx;
      logic        fin;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   frame_bits = 0;
   bit   mon_on = 1'b0;

   bit          m_in_frame = 1'b0;
   bit          eos_pend = 1'b0;
   logic [15:0] m_hold = 16'h0000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a byte is a list of 8 bits; the frame is a running count of bits.
   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      int waited;
      bit ok;
      if (gap > 0) begin
         byte_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      byte_valid = 1'b1;
      byte_in    = b;
      byte_last  = last;
      waited     = 0;
      ok         = 1'b0;
      while (!ok && waited < 40) begin
         @(negedge clk);
         if (ready_a) ok = 1'b1;
         else waited++;
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: byte %0h not accepted within 40 cycles", b);
         @(posedge clk);
         #1 byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         exp_t e;
         e.msb_bit = b[7-k];
         e.lsb_bit = b[k];
         e.idx     = 16'(frame_bits);
         e.fin     = last && (k == 7);
         q.push_back(e);
         if (frame_bits < 65535) frame_bits++;
      end
      if (last) frame_bits = 0;
      #1 byte_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   popped;
      bit   rdy_e;
      bit   acc_e;
      int   rem;
      if (mon_on) begin
         popped = (q.size() > 0);
         e = '0;
         if (popped) e = q.pop_front();
         rem   = q.size();
         rdy_e = (rem == 0) && !(popped && e.fin);
         acc_e = byte_valid && rdy_e && !reset;

         chk("bit_valid_a", valid_a, popped);
         chk("bit_valid_b", valid_b, popped);
         chk("ip_c_msb", ip_a, popped ? e.msb_bit : 1'b0);
         chk("ip_c_lsb", ip_b, popped ? e.lsb_bit : 1'b0);
         chk("bit_index_a", idx_a, popped ? e.idx : m_hold);
         chk("bit_index_b", idx_b, popped ? e.idx : m_hold);
         chk("byte_ready_a", ready_a, rdy_e);
         chk("byte_ready_b", ready_b, rdy_e);
         chk("start_unanchored", start_a, !reset && (acc_e || rem > 0));
         chk("start_anchored", start_b, acc_e && !m_in_frame);
         chk("nfa_reset_a", nfa_a, reset || (!m_in_frame && !acc_e));
         chk("nfa_reset_b", nfa_b, reset || (!m_in_frame && !acc_e));
         chk("eos_a", eos_a, eos_pend);
         chk("eos_b", eos_b, eos_pend);

         if (reset) begin
            q.delete();
            m_in_frame = 1'b0;
            m_hold     = 16'h0000;
            eos_pend   = 1'b0;
         end else begin
            eos_pend = popped && e.fin;
            if (popped) begin
               if (e.fin) begin
                  m_hold     = 16'h0000;
                  m_in_frame = 1'b0;
               end else if (e.idx != 16'hFFFF) begin
                  m_hold = e.idx + 16'h0001;
               end else begin
                  m_hold = e.idx;
               end
            end
            if (acc_e) m_in_frame = 1'b1;
         end
      end
   end

   initial begin
      int nbytes;
      int gap;
      int drain;
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      byte_last  = 1'b0;
      @(posedge clk);
      #1 mon_on = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // single-byte frame
      send_byte(8'hA5, 1'b1, 1);
      // back-to-back two-byte frame, valid held
      send_byte(8'hFF, 1'b0, 3);
      send_byte(8'h00, 1'b1, 0);
      // underrun: 5 idle cycles between the bytes of one frame
      send_byte(8'h3C, 1'b0, 3);
      send_byte(8'hC3, 1'b1, 12);
      // reset while bit 4 of a byte is on ip_c
      send_byte(8'h5A, 1'b0, 2);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      frame_bits = 0;
      // LSB-first check on dut_b
      send_byte(8'h01, 1'b1, 2);

      repeat (40) begin
         nbytes = $urandom_range(1, 4);
         for (int i = 0; i < nbytes; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            send_byte(8'($urandom), (i == nbytes - 1), gap);
         end
      end

      drain = 0;
      while (q.size() > 0 && drain < 40) begin
         @(posedge clk);
         drain++;
      end
      repeat (3) @(posedge clk);
      #1 chk("drain", 16'(q.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
